mm_stream_tx: RTL and testbench



---
 rtl/mm_pkg.sv | 25 ++
 rtl/mm_stream_tx_if.sv | 33 +++
 rtl/mm_tx_buf.sv | 42 ++++
 rtl/mm_stream_tx.sv | 180 ++++++++++++++++++
 tb/tb_mm_stream_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// mm_pkg
// Shared definitions for the matrix-multiply stream transmitter:
//   - tx_state_t : FSM state encoding (IDLE, SEND, COLLECT, DONE)
//   - ELEM_W     : operand element width (4)
//   - RES_W      : result width (8)
//   - CHK_W      : checksum width (16)
//   - N_ELEM_DEF, N_OUT_DEF, TIMEOUT_DEF : default job geometry
package mm_pkg;

    localparam int ELEM_W      = 4;
    localparam int RES_W       = 8;
    localparam int CHK_W       = 16;

    localparam int N_ELEM_DEF  = 16;
    localparam int N_OUT_DEF   = 256;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_COLLECT,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/mm_stream_tx_if.sv
// mm_stream_tx_if
// Operand/result stream between the transmitter and the matrix multiplier.
//   in_valid, in_matrix_A, in_matrix_B : operand stream (transmitter -> multiplier)
//   out_valid, out_matrix              : result stream  (multiplier -> transmitter)
// Modports:
//   master : transmitter side (drives operands, receives results)
//   slave  : multiplier side  (receives operands, drives results)
interface mm_stream_tx_if;
    import mm_pkg::*;

    logic              in_valid;
    logic [ELEM_W-1:0] in_matrix_A;
    logic [ELEM_W-1:0] in_matrix_B;
    logic              out_valid;
    logic [RES_W-1:0]  out_matrix;

    modport master (
        output in_valid,
        output in_matrix_A,
        output in_matrix_B,
        input  out_valid,
        input  out_matrix
    );

    modport slave (
        input  in_valid,
        input  in_matrix_A,
        input  in_matrix_B,
        output out_valid,
        output out_matrix
    );

endinterface

// File: rtl/mm_tx_buf.sv
// mm_tx_buf
// Dual 4-bit operand load buffer (A and B arrays of N_ELEM entries).
//   clk1, rst             : clock and synchronous active-high reset (clears buffer)
//   wr_en, wr_addr        : write strobe and element index (already gated by caller)
//   wr_data_a, wr_data_b  : element values written into A and B
//   rd_addr               : combinational read index
//   rd_data_a, rd_data_b  : element values at rd_addr
module mm_tx_buf
    import mm_pkg::*;
#(
    parameter int N_ELEM = N_ELEM_DEF
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(N_ELEM)-1:0] wr_addr,
    input  logic [ELEM_W-1:0]         wr_data_a,
    input  logic [ELEM_W-1:0]         wr_data_b,
    input  logic [$clog2(N_ELEM)-1:0] rd_addr,
    output logic [ELEM_W-1:0]         rd_data_a,
    output logic [ELEM_W-1:0]         rd_data_b
);

    logic [ELEM_W-1:0] mem_a [N_ELEM];
    logic [ELEM_W-1:0] mem_b [N_ELEM];

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en) begin
            mem_a[wr_addr] <= wr_data_a;
            mem_b[wr_addr] <= wr_data_b;
        end
    end

    assign rd_data_a = mem_a[rd_addr];
    assign rd_data_b = mem_b[rd_addr];

endmodule

// File: rtl/mm_stream_tx.sv
// mm_stream_tx
// Stimulus-side transmitter: holds one A/B operand set, serialises it onto the
// operand stream, then collects N_OUT results, forwarding each with its index
// and flagging completion or idle timeout.
// Ports:
//   clk1, rst                      : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data_a/b    : load-buffer write port (IDLE/DONE only)
//   start                          : job request pulse (IDLE only)
//   busy, done, err_timeout        : job status
//   bus (mm_stream_tx_if.master)   : operand stream out, result stream in
//   res_valid, res_data, res_idx   : registered copy of each accepted result
//   checksum                       : running 16-bit sum of accepted results
// Build option:
//   MM_TX_CHECKSUM_EN : when defined the checksum accumulator is built;
//                       otherwise checksum is tied to 0.
module mm_stream_tx
    import mm_pkg::*;
#(
    parameter int N_ELEM  = N_ELEM_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(N_ELEM)-1:0] wr_addr,
    input  logic [ELEM_W-1:0]         wr_data_a,
    input  logic [ELEM_W-1:0]         wr_data_b,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    mm_stream_tx_if.master            bus,
    output logic                      res_valid,
    output logic [RES_W-1:0]          res_data,
    output logic [$clog2(N_OUT)-1:0]  res_idx,
    output logic [CHK_W-1:0]          checksum
);

    localparam int AW = $clog2(N_ELEM);
    localparam int IW = $clog2(N_OUT);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(N_ELEM - 1);
    localparam logic [IW-1:0] LAST_CNT   = IW'(N_OUT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    tx_state_t         state;
    logic [AW-1:0]     send_idx;
    logic [IW-1:0]     res_cnt;
    logic [TW-1:0]     idle_timer;
    logic              in_valid_q;
    logic [ELEM_W-1:0] in_a_q;
    logic [ELEM_W-1:0] in_b_q;

    logic              buf_wr_en;
    logic [AW-1:0]     rd_addr;
    logic [ELEM_W-1:0] rd_a;
    logic [ELEM_W-1:0] rd_b;

    // The buffer is frozen for the duration of a job.
    assign buf_wr_en = wr_en && (state == ST_IDLE || state == ST_DONE);

    // The read port looks one element ahead so the registered bus shows
    // element i in the i-th SEND cycle; in IDLE it presents element 0.
    assign rd_addr = (state == ST_SEND) ? send_idx + 1'b1 : '0;

    mm_tx_buf #(
        .N_ELEM (N_ELEM)
    ) u_buf (
        .clk1      (clk1),
        .rst       (rst),
        .wr_en     (buf_wr_en),
        .wr_addr   (wr_addr),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    assign bus.in_valid    = in_valid_q;
    assign bus.in_matrix_A = in_a_q;
    assign bus.in_matrix_B = in_b_q;

    // Job FSM with all status, stream and result outputs registered.
    // In COLLECT an accept always takes priority over the idle timer, so a
    // result arriving on the would-be expiry cycle prevents the timeout.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= ST_IDLE;
            send_idx    <= '0;
            res_cnt     <= '0;
            idle_timer  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            in_valid_q  <= 1'b0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_idx     <= '0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_SEND;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                        res_cnt     <= '0;
                        idle_timer  <= '0;
                        send_idx    <= '0;
                        in_valid_q  <= 1'b1;
                        in_a_q      <= rd_a;
                        in_b_q      <= rd_b;
                    end
                end
                ST_SEND: begin
                    if (send_idx == LAST_IDX) begin
                        state      <= ST_COLLECT;
                        in_valid_q <= 1'b0;
                        in_a_q     <= '0;
                        in_b_q     <= '0;
                    end else begin
                        send_idx <= send_idx + 1'b1;
                        in_a_q   <= rd_a;
                        in_b_q   <= rd_b;
                    end
                end
                ST_COLLECT: begin
                    if (bus.out_valid) begin
                        res_valid  <= 1'b1;
                        res_data   <= bus.out_matrix;
                        res_idx    <= res_cnt;
                        res_cnt    <= res_cnt + 1'b1;
                        idle_timer <= '0;
                        if (res_cnt == LAST_CNT) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        idle_timer <= idle_timer + 1'b1;
                        if (idle_timer == TIMER_LAST) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MM_TX_CHECKSUM_EN
    // Running sum of accepted results, wrapping at 16 bits.
    always_ff @(posedge clk1) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum <= '0;
        end else if (state == ST_COLLECT && bus.out_valid) begin
            checksum <= checksum + CHK_W'(bus.out_matrix);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mm_stream_tx.sv
// tb_mm_stream_tx
// Bench for mm_stream_tx: table-loaded send-order job, full collect, timeout,
// expiry race, ignored events during SEND, DONE-state write, mid-job reset.
// Expected values come from a load-buffer model and a result-stream model
// (index count, modulo-2^16 sum, consecutive-idle count).
module tb_mm_stream_tx;

    localparam int N_ELEM  = 16;
    localparam int N_OUT   = 256;
    localparam int TIMEOUT = 1024;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_data_a = '0;
    logic [3:0]  wr_data_b = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [7:0]  res_idx;
    logic [15:0] checksum;

    mm_stream_tx_if bus ();

    mm_stream_tx #(
        .N_ELEM  (N_ELEM),
        .N_OUT   (N_OUT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data_a   (wr_data_a),
        .wr_data_b   (wr_data_b),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .bus         (bus),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_idx     (res_idx),
        .checksum    (checksum)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
    } vec_t;

    vec_t       vecs [N_ELEM];
    logic [3:0] ref_a [N_ELEM];
    logic [3:0] ref_b [N_ELEM];
    logic [3:0] exp_a_s [N_ELEM];
    logic [3:0] exp_b_s [N_ELEM];
    int         exp_sum;
    int         checks = 0;
    int         errors = 0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expChk(input int sum);
`ifdef MM_TX_CHECKSUM_EN
        return 16'(sum);
`else
        return (sum == sum) ? 16'h0 : 16'h0;
`endif
    endfunction

    // Load-buffer write in IDLE; the model buffer follows.
    task automatic applyStimulus(input logic [3:0] addr, input logic [3:0] a, input logic [3:0] b);
        wr_en     = 1'b1;
        wr_addr   = addr;
        wr_data_a = a;
        wr_data_b = b;
        tick();
        wr_en     = 1'b0;
        ref_a[addr] = a;
        ref_b[addr] = b;
    endtask

    task automatic expectFromModel();
        for (int i = 0; i < N_ELEM; i++) begin
            exp_a_s[i] = ref_a[i];
            exp_b_s[i] = ref_b[i];
        end
    endtask

    task automatic startJob();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_sum = 0;
        checkOutput("busy_rise", 32'(busy), 1);
        checkOutput("err_clear_on_start", 32'(err_timeout), 0);
    endtask

    // Operand stream: element i in the i-th cycle after start, no gaps.
    // With inject set, start/wr_en/out_valid are pulsed while sending.
    task automatic sendPhase(input bit inject);
        for (int i = 0; i < N_ELEM; i++) begin
            checkOutput($sformatf("send_valid[%0d]", i), 32'(bus.in_valid), 1);
            checkOutput($sformatf("send_a[%0d]", i), 32'(bus.in_matrix_A), 32'(exp_a_s[i]));
            checkOutput($sformatf("send_b[%0d]", i), 32'(bus.in_matrix_B), 32'(exp_b_s[i]));
            checkOutput($sformatf("send_res_valid[%0d]", i), 32'(res_valid), 0);
            if (inject) begin
                start          = (i == 3);
                wr_en          = (i == 5);
                wr_addr        = 4'd0;
                wr_data_a      = 4'd9;
                wr_data_b      = 4'd9;
                bus.out_valid  = (i == 7) || (i == 15);
                bus.out_matrix = 8'h55;
            end
            tick();
            start         = 1'b0;
            wr_en         = 1'b0;
            bus.out_valid = 1'b0;
        end
        checkOutput("post_send_valid", 32'(bus.in_valid), 0);
        checkOutput("post_send_a", 32'(bus.in_matrix_A), 0);
        checkOutput("post_send_b", 32'(bus.in_matrix_B), 0);
        checkOutput("post_send_res_valid", 32'(res_valid), 0);
        checkOutput("post_send_checksum", 32'(checksum), 32'(expChk(0)));
        checkOutput("post_send_busy", 32'(busy), 1);
    endtask

    // Result responder plus model. fixed_gap < 0 gives random gaps 0..3.
    // abort_at > 0 returns right after that many results were accepted.
    task automatic collectPhase(input int n_send, input bit use_fixed, input logic [7:0] fixed_val,
                                input int fixed_gap, input int abort_at);
        int         sent;
        int         idle;
        int         gap_left;
        bit         finished;
        bit         aborted;
        bit         drive;
        bit         exp_done;
        bit         exp_to;
        logic [7:0] val;
        sent     = 0;
        idle     = 0;
        finished = 1'b0;
        aborted  = 1'b0;
        exp_to   = 1'b0;
        gap_left = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
        for (int cyc = 0; cyc < 5000 && !finished && !aborted; cyc++) begin
            drive    = 1'b0;
            exp_done = 1'b0;
            if (sent < n_send) begin
                if (gap_left == 0) drive = 1'b1;
                else gap_left--;
            end
            val = use_fixed ? fixed_val : 8'($urandom);
            bus.out_valid  = drive;
            bus.out_matrix = val;
            if (drive) begin
                sent++;
                idle    = 0;
                exp_sum = (exp_sum + int'(val)) % 65536;
                if (sent == N_OUT) exp_done = 1'b1;
                gap_left = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
            end else begin
                idle++;
                if (idle == TIMEOUT) begin
                    exp_done = 1'b1;
                    exp_to   = 1'b1;
                end
            end
            tick();
            bus.out_valid = 1'b0;
            checkOutput("res_valid", 32'(res_valid), 32'(drive));
            if (drive) begin
                checkOutput("res_data", 32'(res_data), 32'(val));
                checkOutput("res_idx", 32'(res_idx), sent - 1);
                checkOutput("checksum", 32'(checksum), 32'(expChk(exp_sum)));
            end
            checkOutput("done", 32'(done), 32'(exp_done));
            if (exp_done) finished = 1'b1;
            else if (abort_at > 0 && sent == abort_at) aborted = 1'b1;
        end
        if (!finished && !aborted) begin
            checks++;
            errors++;
            $display("[TB] FAIL collect_bound: got no completion, required one within 5000 cycles");
        end else if (finished) begin
            checkOutput("done_busy", 32'(busy), 1);
            checkOutput("done_err_timeout", 32'(err_timeout), 32'(exp_to));
            checkOutput("done_in_valid", 32'(bus.in_valid), 0);
            // DONE accepts buffer writes but ignores start.
            wr_en     = 1'b1;
            wr_addr   = 4'($urandom_range(1, 15));
            wr_data_a = 4'($urandom);
            wr_data_b = 4'($urandom);
            start     = 1'b1;
            tick();
            ref_a[wr_addr] = wr_data_a;
            ref_b[wr_addr] = wr_data_b;
            wr_en = 1'b0;
            start = 1'b0;
            checkOutput("idle_busy", 32'(busy), 0);
            checkOutput("idle_done", 32'(done), 0);
            checkOutput("idle_in_valid", 32'(bus.in_valid), 0);
            checkOutput("idle_err_sticky", 32'(err_timeout), 32'(exp_to));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.out_valid  = 1'b0;
        bus.out_matrix = '0;
        for (int j = 0; j < N_ELEM; j++) begin
            vecs[j].addr  = 4'(15 - j);
            vecs[j].a     = 4'(15 - j);
            vecs[j].b     = 4'(j);
            vecs[j].exp_a = 4'(j);
            vecs[j].exp_b = 4'(15 - j);
            ref_a[j] = '0;
            ref_b[j] = '0;
        end

        $display("[TB] reset with random inputs");
        rst = 1'b1;
        repeat (3) begin
            wr_en          = 1'($urandom);
            wr_addr        = 4'($urandom);
            wr_data_a      = 4'($urandom);
            wr_data_b      = 4'($urandom);
            start          = 1'($urandom);
            bus.out_valid  = 1'($urandom);
            bus.out_matrix = 8'($urandom);
            tick();
        end
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err_timeout", 32'(err_timeout), 0);
        checkOutput("rst_in_valid", 32'(bus.in_valid), 0);
        checkOutput("rst_in_a", 32'(bus.in_matrix_A), 0);
        checkOutput("rst_in_b", 32'(bus.in_matrix_B), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);
        checkOutput("rst_res_data", 32'(res_data), 0);
        checkOutput("rst_res_idx", 32'(res_idx), 0);
        checkOutput("rst_checksum", 32'(checksum), 0);
        wr_en = 1'b0;
        start = 1'b0;
        bus.out_valid = 1'b0;
        rst = 1'b0;
        tick();

        $display("[TB] table load, send order, full collect of 0xFF");
        for (int j = 0; j < N_ELEM; j++) applyStimulus(vecs[j].addr, vecs[j].a, vecs[j].b);
        for (int j = 0; j < N_ELEM; j++) begin
            exp_a_s[j] = vecs[j].exp_a;
            exp_b_s[j] = vecs[j].exp_b;
        end
        startJob();
        sendPhase(1'b1);
        collectPhase(N_OUT, 1'b1, 8'hFF, -1, 0);
`ifdef MM_TX_CHECKSUM_EN
        checkOutput("full_checksum", 32'(checksum), 32'h0000FF00);
`else
        checkOutput("full_checksum", 32'(checksum), 0);
`endif

        $display("[TB] dropped write check and timeout after 10 results");
        expectFromModel();
        startJob();
        sendPhase(1'b0);
        collectPhase(10, 1'b0, 8'h00, -1, 0);

        $display("[TB] random loads and accept on expiry cycle");
        for (int j = 0; j < 8; j++) applyStimulus(4'($urandom), 4'($urandom), 4'($urandom));
        expectFromModel();
        startJob();
        sendPhase(1'b0);
        collectPhase(2, 1'b0, 8'h00, TIMEOUT - 1, 0);

        $display("[TB] mid-job reset at result 100");
        expectFromModel();
        startJob();
        sendPhase(1'b0);
        collectPhase(N_OUT, 1'b0, 8'h00, -1, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < N_ELEM; j++) begin
            ref_a[j] = '0;
            ref_b[j] = '0;
        end
        exp_sum = 0;
        checkOutput("mrst_busy", 32'(busy), 0);
        checkOutput("mrst_done", 32'(done), 0);
        checkOutput("mrst_in_valid", 32'(bus.in_valid), 0);
        checkOutput("mrst_res_valid", 32'(res_valid), 0);
        checkOutput("mrst_res_idx", 32'(res_idx), 0);
        checkOutput("mrst_checksum", 32'(checksum), 0);
        repeat (3) begin
            tick();
            checkOutput("mrst_no_done", 32'(done), 0);
            checkOutput("mrst_idle", 32'(busy), 0);
        end

        $display("[TB] partial reload after reset and full random job");
        for (int j = 0; j < 6; j++) applyStimulus(4'($urandom), 4'($urandom), 4'($urandom));
        expectFromModel();
        startJob();
        sendPhase(1'b0);
        collectPhase(N_OUT, 1'b0, 8'h00, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
